// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and defaults for the iterative multiply/divide unit.
// Contents: default operand width, command opcode enum, FSM state enum.
package muldiv_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: command/response bundle between the EX stage and muldiv_unit.
// master (EX side): drives start, op, src_a, src_b, flush, hi_read, lo_read;
//                   receives busy, done, div_zero, read_data.
// slave (unit side): the mirror image.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             hi_read;
  logic             lo_read;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] read_data;

  modport master (
    output start, op, src_a, src_b, flush, hi_read, lo_read,
    input  busy, done, div_zero, read_data
  );

  modport slave (
    input  start, op, src_a, src_b, flush, hi_read, lo_read,
    output busy, done, div_zero, read_data
  );

endinterface

// File: rtl/muldiv_core.sv
// muldiv_core: iterative datapath for muldiv_unit.
// Optional feature macro: MULDIV_DIV_EN (adds the restoring divider step).
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   load            latch operand magnitudes, clear accumulator
//   is_signed       operands are two's complement (magnitudes taken on load)
//   src_a, src_b    raw operands
//   step_mul        one radix-2 shift-add step
//   step_div        one restoring shift-subtract step (MULDIV_DIV_EN only)
//   acc_out, lo_out multiply: product {acc, lo}; divide: acc = remainder, lo = quotient
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             step_mul,
`ifdef MULDIV_DIV_EN
  input  logic             step_div,
`endif
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   mul_sum;

  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  always_comb begin
    mag_a = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    mag_b = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;
  end

  // Multiplier bits sit in lo and are consumed LSB first while the product
  // shifts in from the top; the carry out of the add becomes the new acc MSB.
  always_comb begin
    mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, opb} : '0);
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] div_shift;
  logic           div_ge;

  // Remainder in acc, dividend/quotient in lo; the partial remainder is always
  // below the divisor, so the shifted value fits in WIDTH+1 bits and the
  // difference (when taken) fits back into WIDTH bits.
  always_comb begin
    div_shift = {acc, lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opb};
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      lo  <= '0;
      opb <= '0;
    end else if (load) begin
      acc <= '0;
      lo  <= mag_a;
      opb <= mag_b;
    end else if (step_mul) begin
      acc <= mul_sum[WIDTH:1];
      lo  <= {mul_sum[0], lo[WIDTH-1:1]};
    end
`ifdef MULDIV_DIV_EN
    else if (step_div) begin
      acc <= div_ge ? (div_shift[WIDTH-1:0] - opb) : div_shift[WIDTH-1:0];
      lo  <= {lo[WIDTH-2:0], div_ge};
    end
`endif
  end

  assign acc_out = acc;
  assign lo_out  = lo;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO.
// Optional feature macro: MULDIV_DIV_EN (DIV/DIVU support; otherwise ops 2/3
// are ignored and div_zero is tied low).
// Ports:
//   clk   clock
//   rst   asynchronous active-low reset
//   bus   muldiv_if.slave: start/op/src_a/src_b/flush/hi_read/lo_read in,
//         busy/done/div_zero/read_data out
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);

  muldiv_state_e    state;
  muldiv_op_e       op;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] read_q;
  logic             busy_q;
  logic             done_q;
  logic             neg_res;
  logic             is_mul_op;
  logic             is_signed;
  logic             load;
  logic             step_mul;
  logic [WIDTH-1:0] core_acc;
  logic [WIDTH-1:0] core_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  assign op        = muldiv_op_e'(bus.op);
  assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign step_mul  = (state == ST_MUL);

`ifdef MULDIV_DIV_EN
  logic             is_div_op;
  logic             is_div;
  logic             neg_rem;
  logic             div_by_zero;
  logic             div_zero_q;
  logic             step_div;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  assign step_div  = (state == ST_DIV);
  assign load      = (state == ST_IDLE) && bus.start && !bus.flush && (is_mul_op || is_div_op);

  always_comb begin
    quot_fix = neg_res ? -core_lo  : core_lo;
    rem_fix  = neg_rem ? -core_acc : core_acc;
  end

  assign bus.div_zero = div_zero_q;
`else
  assign load         = (state == ST_IDLE) && bus.start && !bus.flush && is_mul_op;
  assign bus.div_zero = 1'b0;
`endif

  always_comb begin
    prod     = {core_acc, core_lo};
    prod_fix = neg_res ? -prod : prod;
  end

  muldiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .is_signed (is_signed),
    .src_a     (bus.src_a),
    .src_b     (bus.src_b),
    .step_mul  (step_mul),
`ifdef MULDIV_DIV_EN
    .step_div  (step_div),
`endif
    .acc_out   (core_acc),
    .lo_out    (core_lo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      read_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      neg_res <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div      <= 1'b0;
      neg_rem     <= 1'b0;
      div_by_zero <= 1'b0;
      div_zero_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_zero_q <= 1'b0;
`endif
      // Reads sample HI/LO before any write on this edge, so they see old values.
      if (bus.lo_read) begin
        read_q <= lo;
      end else if (bus.hi_read) begin
        read_q <= hi;
      end

      case (state)
        ST_IDLE: begin
          if (load) begin
            cnt     <= CNT_W'(WIDTH);
            busy_q  <= 1'b1;
            neg_res <= is_signed && (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
            state   <= ST_MUL;
`ifdef MULDIV_DIV_EN
            is_div      <= is_div_op;
            neg_rem     <= is_signed && bus.src_a[WIDTH-1];
            div_by_zero <= (bus.src_b == '0);
            if (is_div_op) begin
              state <= ST_DIV;
            end
`endif
          end else if (bus.start && !bus.flush) begin
            if (op == OP_MTHI) begin
              hi <= bus.src_a;
            end else if (op == OP_MTLO) begin
              lo <= bus.src_a;
            end
          end
        end

        ST_MUL: begin
          if (bus.flush) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              state <= ST_FIX;
            end
          end
        end

`ifdef MULDIV_DIV_EN
        ST_DIV: begin
          if (bus.flush) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              state <= ST_FIX;
            end
          end
        end
`endif

        ST_FIX: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          if (!bus.flush) begin
            done_q <= 1'b1;
`ifdef MULDIV_DIV_EN
            if (is_div) begin
              if (div_by_zero) begin
                div_zero_q <= 1'b1;
              end else begin
                lo <= quot_fix;
                hi <= rem_fix;
              end
            end else
`endif
            begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end

        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.read_data = read_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (WIDTH=32).
// Covers both builds: divide vectors run when MULDIV_DIV_EN is defined,
// otherwise DIV/DIVU are checked to be ignored.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst;
  int   passed;
  int   failed;
  int   total;
  int   n;
  logic dz;
  logic saw_done;
  logic [31:0] d;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks assume they are entered 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output logic dzo);
    cycles = 0;
    dzo    = 1'b0;
    while (cycles < 40) begin
      tick();
      cycles++;
      if (bus.done) begin
        dzo = bus.div_zero;
        break;
      end
    end
  endtask

  task automatic do_read(input logic use_lo, output logic [31:0] data);
    bus.lo_read = use_lo;
    bus.hi_read = !use_lo;
    tick();
    bus.lo_read = 1'b0;
    bus.hi_read = 1'b0;
    data = bus.read_data;
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    rst = 1'b0;
    bus.start = 1'b0; bus.op = 3'd0; bus.src_a = '0; bus.src_b = '0;
    bus.flush = 1'b0; bus.hi_read = 1'b0; bus.lo_read = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_dz",   {63'd0, bus.div_zero}, 64'd0);
    check("rst_rd",   {32'd0, bus.read_data}, 64'd0);
    rst = 1'b1;
    tick();

    // MULT -3 x 5
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    check("mult_busy", {63'd0, bus.busy}, 64'd1);
    wait_done(n, dz);
    check("mult_lat", 64'(n), 64'd33);
    check("mult_busy_done", {63'd0, bus.busy}, 64'd0);
    do_read(1'b1, d);
    check("mult_lo", {32'd0, d}, 64'hFFFF_FFF1);
    do_read(1'b0, d);
    check("mult_hi", {32'd0, d}, 64'hFFFF_FFFF);

    // MULTU max x max
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n, dz);
    check("multu_lat", 64'(n), 64'd33);
    do_read(1'b1, d);
    check("multu_lo", {32'd0, d}, 64'h0000_0001);
    do_read(1'b0, d);
    check("multu_hi", {32'd0, d}, 64'hFFFF_FFFE);

    // MTHI / MTLO, single cycle, no busy or done
    issue(OP_MTHI, 32'h0000_AAAA, 32'd0);
    check("mthi_busy", {63'd0, bus.busy}, 64'd0);
    check("mthi_done", {63'd0, bus.done}, 64'd0);
    issue(OP_MTLO, 32'h0000_5555, 32'd0);
    do_read(1'b0, d);
    check("mthi_hi", {32'd0, d}, 64'h0000_AAAA);
    bus.lo_read = 1'b1;
    bus.hi_read = 1'b1;
    tick();
    bus.lo_read = 1'b0;
    bus.hi_read = 1'b0;
    check("read_prio_lo", {32'd0, bus.read_data}, 64'h0000_5555);

`ifdef MULDIV_DIV_EN
    // DIVU by zero: full latency, flags, HI/LO untouched
    issue(OP_DIVU, 32'd7, 32'd0);
    check("divz_busy", {63'd0, bus.busy}, 64'd1);
    wait_done(n, dz);
    check("divz_lat", 64'(n), 64'd33);
    check("divz_flag", {63'd0, dz}, 64'd1);
    tick();
    check("divz_pulse", {62'd0, bus.done, bus.div_zero}, 64'd0);
`else
    // Without the divider, DIVU is ignored
    issue(OP_DIVU, 32'd7, 32'd0);
    check("nodiv_busy", {63'd0, bus.busy}, 64'd0);
    tick(); tick();
    check("nodiv_done", {62'd0, bus.done, bus.div_zero}, 64'd0);
`endif

    // Flush mid-MULT; a start while busy is ignored
    issue(OP_MULT, 32'd3, 32'd4);
    tick(); tick(); tick();
    bus.start = 1'b1; bus.op = OP_MTHI; bus.src_a = 32'h0000_1234;
    tick();
    bus.start = 1'b0;
    check("ign_busy", {63'd0, bus.busy}, 64'd1);
    tick(); tick(); tick(); tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_busy", {63'd0, bus.busy}, 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) saw_done = 1'b1;
    end
    check("flush_nodone", {63'd0, saw_done}, 64'd0);
    do_read(1'b0, d);
    check("flush_hi", {32'd0, d}, 64'h0000_AAAA);
    do_read(1'b1, d);
    check("flush_lo", {32'd0, d}, 64'h0000_5555);

`ifdef MULDIV_DIV_EN
    // Signed divide: truncation toward zero, remainder follows dividend
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(n, dz);
    check("div_lat", 64'(n), 64'd33);
    check("div_nodz", {63'd0, dz}, 64'd0);
    do_read(1'b1, d);
    check("div_lo", {32'd0, d}, 64'hFFFF_FFFD);
    do_read(1'b0, d);
    check("div_hi", {32'd0, d}, 64'hFFFF_FFFF);

    // MIN / -1
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, dz);
    check("min_nodz", {63'd0, dz}, 64'd0);
    do_read(1'b1, d);
    check("min_lo", {32'd0, d}, 64'h8000_0000);
    do_read(1'b0, d);
    check("min_hi", {32'd0, d}, 64'h0000_0000);
`endif

    // Back-to-back: new start accepted in the done cycle, read sees new LO
    issue(OP_MULT, 32'd3, 32'd4);
    wait_done(n, dz);
    check("b2b_lat1", 64'(n), 64'd33);
    bus.lo_read = 1'b1;
    issue(OP_MULTU, 32'd6, 32'd7);
    bus.lo_read = 1'b0;
    check("b2b_busy", {63'd0, bus.busy}, 64'd1);
    check("b2b_rd12", {32'd0, bus.read_data}, 64'd12);
    wait_done(n, dz);
    check("b2b_lat2", 64'(n), 64'd33);
    do_read(1'b0, d);
    check("b2b_hi", {32'd0, d}, 64'd0);
    do_read(1'b1, d);
    check("b2b_lo", {32'd0, d}, 64'd42);

    // Asynchronous reset in the middle of an operation
`ifdef MULDIV_DIV_EN
    issue(OP_DIV, 32'd100, 32'd7);
`else
    issue(OP_MULT, 32'd100, 32'd7);
`endif
    tick(); tick(); tick(); tick();
    rst = 1'b0;
    #1;
    check("arst_busy", {63'd0, bus.busy}, 64'd0);
    check("arst_rd", {32'd0, bus.read_data}, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    do_read(1'b1, d);
    check("arst_lo", {32'd0, d}, 64'd0);
    do_read(1'b0, d);
    check("arst_hi", {32'd0, d}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
